// File: rtl/dmem_pkg.sv
// dmem_pkg
// Shared types and helpers for the data-memory load/store unit.
//   funct3_e : load/store access type encodings (instruction bits 14:12)
//   state_e  : response FSM states
//   byte_enable() : lane mask for an access of 2**size_log2 bytes at a byte offset
package dmem_pkg;

  typedef enum logic [2:0] {
    F3_B  = 3'b000,
    F3_H  = 3'b001,
    F3_W  = 3'b010,
    F3_D  = 3'b011,
    F3_BU = 3'b100,
    F3_HU = 3'b101,
    F3_WU = 3'b110
  } funct3_e;

  typedef enum logic {
    IDLE = 1'b0,
    RESP = 1'b1
  } state_e;

  // Mask is built for the widest (8-lane) word; narrower users truncate it.
  function automatic logic [7:0] byte_enable(input logic [1:0] size_log2,
                                             input logic [2:0] offset);
    logic [7:0] mask;
    case (size_log2)
      2'd0:    mask = 8'h01;
      2'd1:    mask = 8'h03;
      2'd2:    mask = 8'h0F;
      default: mask = 8'hFF;
    endcase
    return mask << offset;
  endfunction

  // Low address bits that must be zero for a naturally aligned access.
  function automatic logic [2:0] align_mask(input logic [1:0] size_log2);
    case (size_log2)
      2'd0:    return 3'b000;
      2'd1:    return 3'b001;
      2'd2:    return 3'b011;
      default: return 3'b111;
    endcase
  endfunction

endpackage

// File: rtl/dmem_array.sv
// dmem_array
// Synchronous single-port RAM with per-byte write enables and a registered
// read port. Each byte lane is its own array so it maps onto block RAM with
// byte-write support.
// Ports:
//   clk   in  clock
//   we    in  write strobe (qualified per lane by be)
//   re    in  read strobe; rdata updates on the following edge
//   addr  in  word address
//   be    in  byte-lane enables
//   wdata in  lane-aligned write data
//   rdata out registered read data
module dmem_array #(
  parameter int WORDS  = 128,
  parameter int DATA_W = 32,
  parameter int AW     = $clog2(WORDS)
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic                  re,
  input  logic [AW-1:0]         addr,
  input  logic [DATA_W/8-1:0]   be,
  input  logic [DATA_W-1:0]     wdata,
  output logic [DATA_W-1:0]     rdata
);

  localparam int NB = DATA_W / 8;

  genvar gi;
  generate
    for (gi = 0; gi < NB; gi++) begin : g_lane
      logic [7:0] lane_mem [WORDS];
      logic [7:0] lane_q;

      always_ff @(posedge clk) begin
        if (we && be[gi]) begin
          lane_mem[addr] <= wdata[gi*8 +: 8];
        end
        if (re) begin
          lane_q <= lane_mem[addr];
        end
      end

      assign rdata[gi*8 +: 8] = lane_q;
    end
  endgenerate

endmodule

// File: rtl/dmem_lsu.sv
// dmem_lsu
// Data-memory load/store unit: byte-lane store path, sign/zero-extending load
// path, alignment/legality checking and a busy/valid handshake (load latency 2).
// Ports:
//   clk      in  clock
//   reset    in  synchronous active-high reset
//   MemRead  in  load request (level)
//   MemWrite in  store request (level)
//   a        in  byte address
//   wd       in  right-aligned store data
//   Funct3   in  access type
//   rd       out formatted load data (registered)
//   rd_valid out one-cycle pulse when rd holds a load result
//   busy     out request cannot be accepted this cycle
//   err      out one-cycle pulse on misaligned/illegal access
module dmem_lsu
  import dmem_pkg::*;
#(
  parameter int DM_ADDRESS = 9,
  parameter int DATA_W     = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  MemRead,
  input  logic                  MemWrite,
  input  logic [DM_ADDRESS-1:0] a,
  input  logic [DATA_W-1:0]     wd,
  input  logic [2:0]            Funct3,
  output logic [DATA_W-1:0]     rd,
  output logic                  rd_valid,
  output logic                  busy,
  output logic                  err
);

  localparam int NB      = DATA_W / 8;
  localparam int OFF_W   = $clog2(NB);
  localparam int WORD_AW = DM_ADDRESS - OFF_W;
  localparam int WORDS   = 1 << WORD_AW;
  localparam bit IS_64   = (DATA_W == 64);

  state_e state_reg, state_next;

  // Request decode
  logic [OFF_W-1:0]   off;
  logic [2:0]         off3;
  logic [WORD_AW-1:0] word_idx;
  logic [1:0]         size_log2;
  logic               legal_load, legal_store, misaligned;
  logic               load_go, store_go, store_ok;

  assign off       = a[OFF_W-1:0];
  assign off3      = 3'(off);
  assign word_idx  = a[DM_ADDRESS-1:OFF_W];
  assign size_log2 = Funct3[1:0];
  assign misaligned = |(off3 & align_mask(size_log2));

  always_comb begin
    legal_load  = 1'b0;
    legal_store = 1'b0;
    case (Funct3)
      F3_B, F3_H, F3_W: begin
        legal_load  = 1'b1;
        legal_store = 1'b1;
      end
      F3_BU, F3_HU: legal_load = 1'b1;
      F3_D: begin
        legal_load  = IS_64;
        legal_store = IS_64;
      end
      F3_WU:   legal_load = IS_64;
      default: ;
    endcase
  end

  // A load wins when both strobes are high; the store half is dropped.
  assign load_go  = !busy && MemRead;
  assign store_go = !busy && !MemRead && MemWrite;
  assign store_ok = store_go && legal_store && !misaligned && !reset;

  // Memory
  logic [NB-1:0]     be;
  logic [DATA_W-1:0] wdata, rdata;

  assign be    = NB'(byte_enable(size_log2, off3));
  assign wdata = wd << {off, 3'b000};

  dmem_array #(
    .WORDS  (WORDS),
    .DATA_W (DATA_W),
    .AW     (WORD_AW)
  ) u_array (
    .clk   (clk),
    .we    (store_ok),
    .re    (load_go),
    .addr  (word_idx),
    .be    (be),
    .wdata (wdata),
    .rdata (rdata)
  );

  // FSM
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    busy       = 1'b0;
    case (state_reg)
      IDLE: if (load_go) state_next = RESP;
      RESP: begin
        busy       = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Load context captured at accept, consumed in RESP
  logic [2:0]       f3_reg;
  logic [OFF_W-1:0] off_reg;
  logic             fault_reg;   // illegal/misaligned: return zero
  logic             err_reg;     // fault or dropped store

  // Load formatting
  logic [DATA_W-1:0] shifted, load_fmt;

  always_comb begin
    shifted  = rdata >> {off_reg, 3'b000};
    load_fmt = shifted;
    case (f3_reg)
      F3_B:  load_fmt = DATA_W'($signed(shifted[7:0]));
      F3_BU: load_fmt = DATA_W'(shifted[7:0]);
      F3_H:  load_fmt = DATA_W'($signed(shifted[15:0]));
      F3_HU: load_fmt = DATA_W'(shifted[15:0]);
      F3_W:  load_fmt = DATA_W'($signed(shifted[31:0]));
      F3_WU: load_fmt = DATA_W'(shifted[31:0]);
      default: load_fmt = shifted;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rd        <= '0;
      rd_valid  <= 1'b0;
      err       <= 1'b0;
      f3_reg    <= 3'b000;
      off_reg   <= '0;
      fault_reg <= 1'b0;
      err_reg   <= 1'b0;
    end else begin
      rd_valid <= 1'b0;
      err      <= 1'b0;
      if (load_go) begin
        f3_reg    <= Funct3;
        off_reg   <= off;
        fault_reg <= !legal_load || misaligned;
        err_reg   <= !legal_load || misaligned || MemWrite;
      end
      if (store_go && (!legal_store || misaligned)) begin
        err <= 1'b1;
      end
      if (state_reg == RESP) begin
        rd       <= fault_reg ? '0 : load_fmt;
        rd_valid <= 1'b1;
        err      <= err_reg;
      end
    end
  end

endmodule

// File: tb/tb_dmem_lsu.sv
// tb_dmem_lsu
// Directed bench for dmem_lsu. A 32-bit and a 64-bit instance run in lockstep
// on the same request stream; each comparison picks the instance it targets.
module tb_dmem_lsu;
  import dmem_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        mem_read, mem_write;
  logic [8:0]  addr;
  logic [63:0] wd64;
  logic [2:0]  f3;

  logic [31:0] rd32;
  logic        v32, busy32, err32;
  logic [63:0] rd64;
  logic        v64, busy64, err64;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  dmem_lsu #(.DM_ADDRESS(9), .DATA_W(32)) u_dut32 (
    .clk      (clk),
    .reset    (reset),
    .MemRead  (mem_read),
    .MemWrite (mem_write),
    .a        (addr),
    .wd       (wd64[31:0]),
    .Funct3   (f3),
    .rd       (rd32),
    .rd_valid (v32),
    .busy     (busy32),
    .err      (err32)
  );

  dmem_lsu #(.DM_ADDRESS(9), .DATA_W(64)) u_dut64 (
    .clk      (clk),
    .reset    (reset),
    .MemRead  (mem_read),
    .MemWrite (mem_write),
    .a        (addr),
    .wd       (wd64),
    .Funct3   (f3),
    .rd       (rd64),
    .rd_valid (v64),
    .busy     (busy64),
    .err      (err64)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end else begin
      $display("ok   %s: 0x%0h", tag, got);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Store accepted in the current cycle; returns err seen in the next cycle.
  task automatic do_store(input logic [2:0] fn, input logic [8:0] ad, input logic [63:0] d,
                          output logic e32, output logic e64);
    f3 = fn; addr = ad; wd64 = d; mem_write = 1'b1;
    tick();
    mem_write = 1'b0;
    e32 = err32;
    e64 = err64;
    $display("store f3=%0d a=0x%0h wd=0x%0h err32=%0b err64=%0b", fn, ad, d, e32, e64);
  endtask

  // Load accepted in the current cycle; checks the two-cycle handshake.
  task automatic do_load(input string tag, input logic [2:0] fn, input logic [8:0] ad,
                         output logic [31:0] r32, output logic [63:0] r64,
                         output logic e32, output logic e64);
    f3 = fn; addr = ad; mem_read = 1'b1;
    tick();
    check({tag, " busy"}, 64'(busy32), 64'd1);
    check({tag, " no_early_valid"}, 64'(v32), 64'd0);
    mem_read = 1'b0;
    tick();
    check({tag, " valid"}, 64'(v32), 64'd1);
    check({tag, " valid64"}, 64'(v64), 64'd1);
    check({tag, " busy_clear"}, 64'(busy32), 64'd0);
    r32 = rd32; r64 = rd64; e32 = err32; e64 = err64;
    $display("load %s f3=%0d a=0x%0h rd32=0x%0h rd64=0x%0h", tag, fn, ad, r32, r64);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] r32;
    logic [63:0] r64;
    logic        e32, e64;

    reset = 1'b1; mem_read = 1'b0; mem_write = 1'b0;
    addr = '0; wd64 = '0; f3 = 3'b000;

    // Reset values
    tick(); tick();
    check("reset rd", 64'(rd32), 64'd0);
    check("reset rd_valid", 64'(v32), 64'd0);
    check("reset err", 64'(err32), 64'd0);
    check("reset busy", 64'(busy32), 64'd0);
    reset = 1'b0;

    // Reset held two cycles while a load is in flight
    f3 = F3_W; addr = 9'h000; mem_read = 1'b1;
    tick();
    check("inflight busy", 64'(busy32), 64'd1);
    mem_read = 1'b0; reset = 1'b1;
    tick(); tick();
    reset = 1'b0;
    check("rst_inflight rd", 64'(rd32), 64'd0);
    check("rst_inflight rd_valid", 64'(v32), 64'd0);
    check("rst_inflight err", 64'(err32), 64'd0);
    check("rst_inflight busy", 64'(busy32), 64'd0);
    tick();
    check("rst_inflight no_late_valid", 64'(v32), 64'd0);

    // SW then LW
    do_store(F3_W, 9'h010, 64'h0000_0000_DEAD_BEEF, e32, e64);
    check("sw err", 64'(e32), 64'd0);
    do_load("lw10", F3_W, 9'h010, r32, r64, e32, e64);
    check("lw10 rd", 64'(r32), 64'hDEAD_BEEF);
    check("lw10 err", 64'(e32), 64'd0);
    check("lw10 rd64 sext", r64, 64'hFFFF_FFFF_DEAD_BEEF);

    // Byte/half stores over a zeroed word
    do_store(F3_W, 9'h010, 64'h0, e32, e64);
    do_store(F3_B, 9'h011, 64'h80, e32, e64);
    check("sb err", 64'(e32), 64'd0);
    do_store(F3_H, 9'h012, 64'h1234, e32, e64);
    check("sh err", 64'(e32), 64'd0);
    do_load("lw_merge", F3_W, 9'h010, r32, r64, e32, e64);
    check("lw_merge rd", 64'(r32), 64'h1234_8000);
    do_load("lb11", F3_B, 9'h011, r32, r64, e32, e64);
    check("lb11 rd", 64'(r32), 64'hFFFF_FF80);
    do_load("lbu11", F3_BU, 9'h011, r32, r64, e32, e64);
    check("lbu11 rd", 64'(r32), 64'h0000_0080);
    do_load("lh12", F3_H, 9'h012, r32, r64, e32, e64);
    check("lh12 rd", 64'(r32), 64'h0000_1234);

    // Misalignment
    do_load("lw12_mis", F3_W, 9'h012, r32, r64, e32, e64);
    check("lw12_mis rd", 64'(r32), 64'd0);
    check("lw12_mis err", 64'(e32), 64'd1);
    do_store(F3_H, 9'h013, 64'hABCD, e32, e64);
    check("sh13_mis err", 64'(e32), 64'd1);
    tick();
    check("sh13_mis err_one_cycle", 64'(err32), 64'd0);
    do_load("lw_after_mis", F3_W, 9'h010, r32, r64, e32, e64);
    check("lw_after_mis rd", 64'(r32), 64'h1234_8000);

    // Doubleword path (legal only on the 64-bit instance)
    do_store(F3_D, 9'h008, 64'h8000_0000_1234_5678, e32, e64);
    check("sd err64", 64'(e64), 64'd0);
    check("sd err32 illegal", 64'(e32), 64'd1);
    do_load("lwu0c", F3_WU, 9'h00C, r32, r64, e32, e64);
    check("lwu0c rd64", r64, 64'h0000_0000_8000_0000);
    check("lwu0c err32 illegal", 64'(e32), 64'd1);
    check("lwu0c rd32 zero", 64'(r32), 64'd0);
    do_load("lw0c", F3_W, 9'h00C, r32, r64, e32, e64);
    check("lw0c rd64", r64, 64'hFFFF_FFFF_8000_0000);
    do_load("ld08", F3_D, 9'h008, r32, r64, e32, e64);
    check("ld08 rd64", r64, 64'h8000_0000_1234_5678);
    check("ld08 err64", 64'(e64), 64'd0);
    check("ld08 err32", 64'(e32), 64'd1);
    check("ld08 rd32 zero", 64'(r32), 64'd0);

    // Back-to-back: request held through busy, both strobes high
    f3 = F3_W; addr = 9'h010; mem_read = 1'b1;
    tick();
    check("b2b busy", 64'(busy32), 64'd1);
    mem_write = 1'b1; wd64 = 64'hCAFE_F00D;
    tick();
    check("b2b first valid", 64'(v32), 64'd1);
    check("b2b first rd", 64'(rd32), 64'h1234_8000);
    check("b2b first err", 64'(err32), 64'd0);
    check("b2b accept_ready", 64'(busy32), 64'd0);
    tick();
    mem_read = 1'b0; mem_write = 1'b0;
    check("b2b second busy", 64'(busy32), 64'd1);
    check("b2b second not_valid", 64'(v32), 64'd0);
    check("b2b dropped_store no_err_yet", 64'(err32), 64'd0);
    tick();
    check("b2b second valid", 64'(v32), 64'd1);
    check("b2b second rd", 64'(rd32), 64'h1234_8000);
    check("b2b second err", 64'(err32), 64'd1);
    do_load("lw_after_drop", F3_W, 9'h010, r32, r64, e32, e64);
    check("lw_after_drop rd", 64'(r32), 64'h1234_8000);
    check("lw_after_drop err", 64'(e32), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/dmem_lsu.md
# dmem_lsu

Parametrised data-memory load/store unit for the single-cycle/multi-cycle RISC-V datapath. Replaces the flat word memory with a byte-lane-aware store path, sign/zero-extending load path, alignment checking and a busy/valid handshake so the core can stall on loads. Sits between the ALU result/register-file read port and the write-back mux, with an internal byte-enable RAM.

## Interface

- DM_ADDRESS, 9, byte-address width; depth = 2^(DM_ADDRESS - log2(DATA_W/8)) words
- DATA_W, 32, data width; legal values 32 or 64; NB = DATA_W/8 byte lanes

- clk  in  1  clock; all state updates on rising edge
- reset  in  1  synchronous, active-high
- MemRead  in  1  load request (level, from control unit)
- MemWrite  in  1  store request (level, from control unit)
- a  in  DM_ADDRESS  byte address (LSBs of ALU output)
- wd  in  DATA_W  store data, right-aligned
- Funct3  in  3  instruction bits 14:12
- rd  out  DATA_W  formatted load data, registered
- rd_valid  out  1  one-cycle pulse: rd holds load result
- busy  out  1  unit cannot accept a request this cycle
- err  out  1  one-cycle pulse: misaligned or illegal access

## Operation

- Request accepted in a cycle where busy=0 and MemRead or MemWrite=1. Both high: load accepted, store dropped, err pulses with the load result.
- Funct3: 000 B (signed), 001 H (signed), 010 W (signed when DATA_W=64), 011 D (DATA_W=64 only), 100 BU, 101 HU, 110 WU (DATA_W=64 only). 111, or D/WU at DATA_W=32 -> illegal. Store legal only for 000/001/010/011.
- Alignment: H requires a[0]=0, W a[1:0]=0, D a[2:0]=0. Violation -> misaligned.
- Store: lane offset = a[log2(NB)-1:0]; wd low bytes shifted into that lane; byte-enable set only for access size (B=1, H=2, W=4, D=8 lanes). Word index = a >> log2(NB). Illegal/misaligned store: no array write, err pulse.
- Load: whole word read; selected bytes shifted down by lane offset; sign-extended from bit 7/15/31 for signed types, zero-extended for U types; D passes whole word. Illegal/misaligned load: rd=0, err=1, normal latency.
- FSM states: IDLE, RESP. IDLE + accepted load -> RESP (capture Funct3, lane offset, err flag; array read issued). RESP -> IDLE unconditionally. Stores never leave IDLE.
- busy = (state == RESP).
- Memory contents not initialised or cleared by reset.

## Timing

- Reset values: rd=0, rd_valid=0, err=0, state=IDLE, busy=0.
- Store accepted in cycle N: array written at edge ending N; load accepted in N+1 to same address returns new data.
- Load accepted in cycle N: array read at edge ending N, state RESP in N+1 (busy=1); rd/rd_valid registered at edge ending N+1, visible in N+2. Latency 2.
- Next request accepted earliest in N+2 (same cycle as rd_valid); store in N+2 does not disturb rd.
- err for stores visible in N+1; for loads coincident with rd_valid.
- Requests while busy=1 ignored; control must hold MemRead/MemWrite until accepted.
- reset asserted in any state: next cycle IDLE, rd_valid=0, err=0, rd=0; in-flight load discarded; same-cycle store suppressed.

## Structure

- Package dmem_pkg: funct3 enum (F3_B, F3_H, F3_W, F3_D, F3_BU, F3_HU, F3_WU), state enum (IDLE, RESP), function computing byte-enable from size and offset.
- Sub-module dmem_array: synchronous single-port RAM, NB byte-enables, registered read data; parametrised on word count and DATA_W.
- Alignment check, lane shift and extension logic stay in dmem_lsu.

## Test plan

- Reset: hold reset 2 cycles during a pending load -> rd=0, rd_valid=0, err=0, busy=0 following cycle.
- SW 0xDEADBEEF @0x10, then LW @0x10 -> rd_valid two cycles after accept, rd=0xDEADBEEF, busy high exactly one cycle.
- SB 0x80 @0x11, SH 0x1234 @0x12 over zeroed word @0x10 -> LW=0x12348000; LB @0x11=0xFFFFFF80; LBU @0x11=0x00000080; LH @0x12=0x00001234.
- Misaligned LW @0x12 -> rd=0, err=1 with rd_valid; misaligned SH @0x13 -> err pulse next cycle, word unchanged on readback.
- DATA_W=64: SD 0x8000000012345678 @0x08, LWU @0x0C -> 0x0000000080000000, LW @0x0C -> 0xFFFFFFFF80000000; LD at DATA_W=32 -> err.
- Back-to-back: LW then request held during busy, simultaneous MemRead+MemWrite -> load served, store dropped, err=1.
